// File: rtl/x_ring_buffer.sv
// Multi-channel operand buffer: round-robin serial load into CH circular word
// registers, then lockstep rotation with position tracking, wrap pulse and rewind.
module x_ring_buffer #(
  parameter int DW    = 8,
  parameter int CH    = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     load_en,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  output logic                     in_ready,
  input  logic                     shift,
  input  logic                     rewind,
  output logic [CH*DW-1:0]         out_data,
  output logic [$clog2(DEPTH)-1:0] pos,
  output logic                     load_done,
  output logic                     wrap
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(CH*DEPTH) + 1;
  localparam int LW = DEPTH * DW;
  localparam logic [CW-1:0] CNT_LAST = CW'(CH*DEPTH - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(DEPTH - 1);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] chan_q [CH];
  logic [LW-1:0] chan_d [CH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          wrap_q, wrap_d;
  logic          accept;
  logic          do_rewind;
  logic          do_shift;
  logic [PW-1:0] rew_amt;
  int            sel;

  // Rotate a channel left by k words; the head (MSB word) wraps into the LSB.
  function automatic logic [LW-1:0] rotl(input logic [LW-1:0] v, input logic [PW-1:0] k);
    logic [LW-1:0] r;
    int            src;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src = (i + DEPTH - int'(k)) % DEPTH;
      r[i*DW +: DW] = v[src*DW +: DW];
    end
    return r;
  endfunction

  assign accept    = in_valid & in_ready;
  assign do_rewind = (state_q == RUN) & rewind;
  assign do_shift  = (state_q == RUN) & shift & ~rewind;
  // DEPTH is a power of two, so (DEPTH - pos) mod DEPTH is simply -pos.
  assign rew_amt   = PW'(0) - pos_q;
  assign sel       = int'(cnt_q) % CH;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LOAD;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr)                              state_d = LOAD;
    else if (accept && cnt_q == CNT_LAST) state_d = RUN;
  end

  always_comb begin
    in_ready  = 1'b0;
    load_done = 1'b0;
    case (state_q)
      LOAD:    in_ready  = load_en;
      RUN:     load_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    wrap_d = 1'b0;
    for (int c = 0; c < CH; c++) chan_d[c] = chan_q[c];
    if (clr) begin
      cnt_d = '0;
      pos_d = '0;
      for (int c = 0; c < CH; c++) chan_d[c] = '0;
    end else if (accept) begin
      for (int c = 0; c < CH; c++) begin
        if (c == sel) chan_d[c] = {chan_q[c][LW-DW-1:0], in_data};
      end
      cnt_d = cnt_q + CW'(1);
    end else if (do_rewind) begin
      for (int c = 0; c < CH; c++) chan_d[c] = rotl(chan_q[c], rew_amt);
      pos_d = '0;
    end else if (do_shift) begin
      for (int c = 0; c < CH; c++) chan_d[c] = rotl(chan_q[c], PW'(1));
      pos_d  = pos_q + PW'(1);
      wrap_d = (pos_q == POS_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) chan_q[c] <= '0;
      cnt_q  <= '0;
      pos_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      for (int c = 0; c < CH; c++) chan_q[c] <= chan_d[c];
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < CH; c++) out_data[c*DW +: DW] = chan_q[c][LW-DW +: DW];
  end

  assign pos  = pos_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_x_ring_buffer.sv
// Directed + randomized bench for x_ring_buffer against a sample-list reference model.
module tb_x_ring_buffer;
  localparam int DW = 8, CH = 4, DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clr = 1'b0, load_en = 1'b0, in_valid = 1'b0, shift = 1'b0, rewind = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready, load_done, wrap;
  logic [CH*DW-1:0] out_data;
  logic [2:0]      pos;

  int checks = 0;
  int errors = 0;

  // Reference model: list of accepted samples, run flag, rotation count, wrap flag.
  logic [7:0] m_s[$];
  bit         m_run  = 0;
  int         m_rot  = 0;
  bit         m_wrap = 0;

  x_ring_buffer #(.DW(DW), .CH(CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load_en(load_en), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .shift(shift), .rewind(rewind),
    .out_data(out_data), .pos(pos), .load_done(load_done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Channel c head = c-th sample of its list advanced by rot; in LOAD only full channels show data.
  function automatic logic [31:0] exp_out();
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) begin
      if (m_run) v[c*DW +: DW] = m_s[c + CH*m_rot];
      else if (m_s.size() > c + CH*(DEPTH-1)) v[c*DW +: DW] = m_s[c];
    end
    return v;
  endfunction

  task automatic check_all(input string ph);
    chk({ph, "_out"},   64'(out_data),  64'(exp_out()));
    chk({ph, "_pos"},   64'(pos),       64'(m_rot));
    chk({ph, "_done"},  64'(load_done), 64'(m_run));
    chk({ph, "_wrap"},  64'(wrap),      64'(m_wrap));
    chk({ph, "_ready"}, 64'(in_ready),  64'(load_en & !m_run));
  endtask

  task automatic model_reset();
    m_s.delete();
    m_run = 0; m_rot = 0; m_wrap = 0;
  endtask

  // One clock: advance the model on the current inputs, clock the DUT, check.
  task automatic step(input string ph);
    if (clr) begin
      model_reset();
    end else if (in_valid && load_en && !m_run) begin
      m_s.push_back(in_data);
      if (m_s.size() == CH*DEPTH) m_run = 1;
      m_wrap = 0;
    end else if (m_run && rewind) begin
      m_rot = 0; m_wrap = 0;
    end else if (m_run && shift) begin
      m_wrap = (m_rot == DEPTH-1);
      m_rot  = (m_rot + 1) % DEPTH;
    end else begin
      m_wrap = 0;
    end
    @(posedge clk); #1;
    check_all(ph);
  endtask

  task automatic async_reset(input string ph);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all(ph);
    @(negedge clk) rst = 1'b1;
  endtask

  // Load until stop_at samples accepted; gaps adds random valid, a load_en drop and shift noise.
  task automatic load_frame(input string ph, input int stop_at, input bit gaps, input bit rnd);
    int guard;
    guard = 0;
    while (m_s.size() < stop_at && guard < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      load_en  = !(gaps && guard >= 10 && guard < 15);
      shift    = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!in_valid)  in_data = 8'($urandom);
      else if (rnd)   in_data = 8'($urandom);
      else            in_data = 8'(m_s.size());
      step(ph);
      guard++;
    end
    in_valid = 1'b0; shift = 1'b0;
    chk({ph, "_bound"}, 64'(m_s.size()), 64'(stop_at));
  endtask

  task automatic shifts(input string ph, input int n);
    shift = 1'b1;
    for (int i = 0; i < n; i++) step(ph);
    shift = 1'b0;
  endtask

  initial begin
    #3;
    model_reset();
    check_all("reset");
    load_en = 1'b1; #1;
    check_all("reset_ready");
    @(negedge clk) rst = 1'b1;

    // Contiguous load of 0x00..0x1F
    load_frame("load", CH*DEPTH, 0, 0);
    chk("load_layout", 64'(out_data), 64'h03020100);
    chk("load_done_hi", 64'(load_done), 64'd1);
    chk("load_ready_lo", 64'(in_ready), 64'd0);

    // Single shift, then full revolution with wrap
    shifts("shift1", 1);
    chk("shift1_layout", 64'(out_data), 64'h07060504);
    shifts("shift8", 7);
    chk("shift8_layout", 64'(out_data), 64'h03020100);
    chk("shift8_wrap", 64'(wrap), 64'd1);
    step("idle");
    chk("wrap_one_cycle", 64'(wrap), 64'd0);

    // Shift 3, rewind, rewind at pos 0 (with shift held: rewind wins)
    shifts("sh3", 3);
    rewind = 1'b1;
    step("rew");
    chk("rew_layout", 64'(out_data), 64'h03020100);
    shift = 1'b1;
    step("rew0");
    rewind = 1'b0; shift = 1'b0;
    chk("rew0_pos", 64'(pos), 64'd0);

    // Random shift / rewind traffic
    for (int i = 0; i < 60; i++) begin
      shift  = 1'($urandom_range(0, 1));
      rewind = ($urandom_range(0, 5) == 0);
      step("rnd_run");
    end
    shift = 1'b0; rewind = 1'b0;

    // Overflow attempts are refused
    in_valid = 1'b1; in_data = 8'hFF;
    for (int i = 0; i < 4; i++) step("ovf");
    in_valid = 1'b0;

    // clr together with shift
    shifts("pre_clr", 2);
    clr = 1'b1; shift = 1'b1;
    step("clr");
    clr = 1'b0; shift = 1'b0;
    chk("clr_out", 64'(out_data), 64'd0);

    // Gapped load with load_en drop and shift noise
    load_frame("gap", CH*DEPTH, 1, 0);
    chk("gap_layout", 64'(out_data), 64'h03020100);

    // Random-data frame after clr
    clr = 1'b1; step("clr2"); clr = 1'b0;
    load_frame("rload", CH*DEPTH, 0, 1);
    shifts("rload_sh", 5);

    // Async reset mid-load at cnt = 17
    clr = 1'b1; step("clr3"); clr = 1'b0;
    load_frame("part", 17, 0, 0);
    async_reset("rst_load");
    load_frame("reload", CH*DEPTH, 0, 0);
    chk("reload_layout", 64'(out_data), 64'h03020100);

    // Async reset in RUN at pos 5
    shifts("to5", 5);
    chk("pos5", 64'(pos), 64'd5);
    async_reset("rst_run");
    load_en = 1'b1;
    load_frame("reload2", CH*DEPTH, 0, 0);
    chk("reload2_layout", 64'(out_data), 64'h03020100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
